// File: rtl/game_flow_if.sv
// game_flow_if: bundles the playfield/video-side signals of game_flow_control.
//   master : drives frame strobe, key, life/score and the three screen pixels;
//            observes start, screenSel, win, highScore, newHighScore, RGB_out.
//   slave  : the game sequencer itself (mirror directions).
interface game_flow_if;
  logic        startOfFrame;
  logic        keyStartIsPressed;
  logic [3:0]  life;
  logic [15:0] score;
  logic [7:0]  RGB_screen_start;
  logic [7:0]  RGB_screen_main;
  logic [7:0]  RGB_screen_end;
  logic        start;
  logic [1:0]  screenSel;
  logic        win;
  logic [15:0] highScore;
  logic        newHighScore;
  logic [7:0]  RGB_out;

  modport master (
    output startOfFrame, keyStartIsPressed, life, score,
           RGB_screen_start, RGB_screen_main, RGB_screen_end,
    input  start, screenSel, win, highScore, newHighScore, RGB_out
  );

  modport slave (
    input  startOfFrame, keyStartIsPressed, life, score,
           RGB_screen_start, RGB_screen_main, RGB_screen_end,
    output start, screenSel, win, highScore, newHighScore, RGB_out
  );
endinterface

// File: rtl/game_flow_control.sv
// game_flow_control: top-level game sequencer START -> MAIN -> END -> START.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : game_flow_if.slave
//     in : startOfFrame, keyStartIsPressed, life, score, RGB_screen_{start,main,end}
//     out: start (1-cycle launch pulse), screenSel (registered state),
//          win / newHighScore (valid in END), highScore, RGB_out (registered mux)
// Build option: define GAME_FLOW_ATTRACT_EN to make an idle START screen fall
// through to END after 600 frames (attract loop).
module game_flow_control #(
  parameter logic [15:0] WIN_SCORE    = 16'd999,
  parameter int          GUARD_FRAMES = 2,
  parameter int          END_FRAMES   = 180
) (
  input  logic         clk,
  input  logic         reset,
  game_flow_if.slave   bus
);
  typedef enum logic [1:0] {S_START = 2'd0, S_MAIN = 2'd1, S_END = 2'd2} state_e;

  localparam int GW = (GUARD_FRAMES < 1) ? 1 : $clog2(GUARD_FRAMES + 1);
  localparam int EW = (END_FRAMES < 2) ? 1 : $clog2(END_FRAMES);

  state_e        state_q, state_d;
  logic          key_prev_q;
  logic [GW-1:0] guard_q, guard_d;
  logic [EW-1:0] end_q, end_d;
  logic          start_q, start_d;
  logic [1:0]    sel_q;
  logic          win_q, win_d;
  logic          nhs_q, nhs_d;
  logic [15:0]   hs_q, hs_d;
  logic [7:0]    rgb_q, rgb_d;

  logic press, guard_full;
  logic to_main, to_end, to_start, win_now;

  // Only the rising edge of the key acts; key_prev resets high so a key held
  // through reset is not seen as a press.
  assign press      = bus.keyStartIsPressed & ~key_prev_q;
  assign guard_full = (guard_q == GW'(GUARD_FRAMES));

`ifdef GAME_FLOW_ATTRACT_EN
  localparam int ATTRACT_FRAMES = 600;
  logic [9:0] attract_q, attract_d;
  logic       attract_done;
  assign attract_done = bus.startOfFrame && (attract_q == 10'(ATTRACT_FRAMES - 1));
`else
  logic       attract_done;
  assign attract_done = 1'b0;
`endif

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_START;
      key_prev_q <= 1'b1;
      guard_q    <= '0;
      end_q      <= '0;
      start_q    <= 1'b0;
      sel_q      <= 2'd0;
      win_q      <= 1'b0;
      nhs_q      <= 1'b0;
      hs_q       <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= bus.keyStartIsPressed;
      guard_q    <= guard_d;
      end_q      <= end_d;
      start_q    <= start_d;
      sel_q      <= state_q;
      win_q      <= win_d;
      nhs_q      <= nhs_d;
      hs_q       <= hs_d;
      rgb_q      <= rgb_d;
    end
  end

`ifdef GAME_FLOW_ATTRACT_EN
  always_ff @(posedge clk) begin
    if (reset) attract_q <= '0;
    else       attract_q <= attract_d;
  end
`endif

  // Next-state logic
  always_comb begin
    to_main  = 1'b0;
    to_end   = 1'b0;
    to_start = 1'b0;
    win_now  = 1'b0;
    state_d  = state_q;
    case (state_q)
      S_START: begin
        if (press)             to_main = 1'b1;
        else if (attract_done) to_end  = 1'b1;
      end
      S_MAIN: begin
        // life/score are stale until the playfield has seen GUARD_FRAMES frames
        if (bus.startOfFrame && guard_full) begin
          if (bus.score >= WIN_SCORE) begin
            to_end  = 1'b1;
            win_now = 1'b1;
          end else if (bus.life == 4'd0) begin
            to_end  = 1'b1;
          end
        end
      end
      S_END: begin
        if (press || (bus.startOfFrame && end_q == EW'(END_FRAMES - 1)))
          to_start = 1'b1;
      end
      default: to_start = 1'b1;
    endcase
    if (to_main)  state_d = S_MAIN;
    if (to_end)   state_d = S_END;
    if (to_start) state_d = S_START;
  end

  // Output / datapath next values
  always_comb begin
    start_d = to_main;

    guard_d = guard_q;
    if (to_main)
      guard_d = '0;
    else if (state_q == S_MAIN && bus.startOfFrame && !guard_full)
      guard_d = guard_q + 1'b1;

    end_d = end_q;
    if (to_end)
      end_d = '0;
    else if (state_q == S_END && bus.startOfFrame)
      end_d = end_q + 1'b1;

    // Result flags are latched on entry to END (attract entry gives 0/0)
    // and held until START is re-entered.
    win_d = win_q;
    nhs_d = nhs_q;
    hs_d  = hs_q;
    if (to_end) begin
      win_d = win_now;
      nhs_d = 1'b0;
      if (state_q == S_MAIN && bus.score > hs_q) begin
        hs_d  = bus.score;
        nhs_d = 1'b1;
      end
    end
    if (to_start) begin
      win_d = 1'b0;
      nhs_d = 1'b0;
    end

    case (state_q)
      S_MAIN:  rgb_d = bus.RGB_screen_main;
      S_END:   rgb_d = bus.RGB_screen_end;
      default: rgb_d = bus.RGB_screen_start;
    endcase
  end

`ifdef GAME_FLOW_ATTRACT_EN
  always_comb begin
    attract_d = attract_q;
    if (state_q != S_START || press)
      attract_d = '0;
    else if (bus.startOfFrame)
      attract_d = attract_q + 1'b1;
  end
`endif

  assign bus.start        = start_q;
  assign bus.screenSel    = sel_q;
  assign bus.win          = win_q;
  assign bus.highScore    = hs_q;
  assign bus.newHighScore = nhs_q;
  assign bus.RGB_out      = rgb_q;
endmodule

// File: doc/game_flow_control.md
Name: game_flow_control

Overview:
- Top-level game sequencer that wraps the main playfield stage, both upstream and downstream of it.
- Upstream role: generates the one-cycle start pulse that launches a game.
- Downstream role: consumes life and score, and decides win or game over.
- Also tracks the high score and selects which screen's RGB drives the VGA output: start, main or end screen.

Parameters:
WIN_SCORE, 16'd999, score at or above which the game is won
GUARD_FRAMES, 2, number of startOfFrame pulses in MAIN before life/score are evaluated (lets playfield counters reload)
END_FRAMES, 180, frames the end screen stays up before auto-return to start screen

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
keyStartIsPressed  in  1  level, start/continue key (key5)
life  in  4  remaining lives from playfield
score  in  16  current score from playfield
RGB_screen_start  in  8  start screen pixel
RGB_screen_main  in  8  playfield pixel
RGB_screen_end  in  8  end screen pixel
start  out  1  one-cycle pulse launching a new game
screenSel  out  2  0=START, 1=MAIN, 2=END
win  out  1  last game was won (valid in END)
highScore  out  16  best score since reset
newHighScore  out  1  last game set a new high score (valid in END)
RGB_out  out  8  selected pixel, registered

Behaviour:
- Single clock domain.
- Synchronous active-high reset puts the block in these values:
  - state=START, screenSel=0, start=0, win=0, newHighScore=0, highScore=0, RGB_out=0.
  - Guard and end counters=0.
  - keyPrev=1, so a key held through reset is not a press.
- Key edge:
  - keyPrev is registered every cycle.
  - press = keyStartIsPressed & ~keyPrev. Only edges act; a held key never retriggers.
- States:
  - START: on press -> MAIN. start=1 for exactly the following cycle. Guard counter cleared.
  - MAIN:
    - Each startOfFrame increments the guard counter, saturating at GUARD_FRAMES.
    - Until saturated, life/score are ignored.
    - Once saturated, evaluate on each startOfFrame:
      - score >= WIN_SCORE -> END with win=1.
      - else life==0 -> END with win=0.
      - Win has priority when both hold on the same frame.
    - Key presses are ignored in MAIN.
  - END:
    - The end counter increments on each startOfFrame.
    - Exit to START when the counter reaches END_FRAMES-1 on a startOfFrame, or on a press, whichever comes first.
    - A press in the same cycle as the timeout takes the same single transition.
    - win and newHighScore are held through END and cleared on entering START.
- High score:
  - Compared and updated only on the MAIN->END transition cycle, using that cycle's score.
  - If score > highScore: highScore <= score, newHighScore=1.
  - Equal scores do not set newHighScore.
  - Unsigned 16-bit compare; no wrap.
- Screen select:
  - screenSel is a registered copy of state.
  - RGB_out is registered from the input selected by the current state: 1 cycle latency from RGB inputs.
  - screenSel=3 is never produced; the mux defaults to RGB_screen_start.
- start pulse:
  - Exactly one cycle per game.
  - Never asserted outside the START->MAIN transition.
- Reset mid-game returns to START and clears highScore.
- startOfFrame and a press coinciding in START: the press is honoured and the guard count starts from 0.

Optional Feature:
- Macro: GAME_FLOW_ATTRACT_EN.
- Defined:
  - START also counts frames.
  - After 600 frames without a press, it goes to END with win=0, highScore unchanged and newHighScore=0. This is the attract/demo loop, so high-score and end screens cycle on an idle cabinet.
  - The frame count resets on any press or on state entry.
- Undefined: START waits indefinitely for a press; the counter logic is absent.

Test Plan:
- Reset held while key held high, then release reset with key still high -> no start, state START; release key, press again -> start=1 one cycle later, screenSel=1 the cycle after.
- In MAIN, drive life=0 from cycle 0, 5 frames -> no exit during first 2 frames; END on 3rd startOfFrame; win=0.
- In MAIN after guard, score=999 and life=0 on same frame -> END, win=1, highScore=999, newHighScore=1.
- Second game ends with score=999 -> highScore stays 999, newHighScore=0; third game ends with score=1000 -> highScore=1000, newHighScore=1.
- In END, no key: 180 startOfFrame pulses -> returns to START on 180th, win and newHighScore cleared; repeat with press on frame 10 -> returns to START immediately.
- RGB_screen_main=8'hA5 while in MAIN -> RGB_out=8'hA5 one cycle later; assert reset mid-MAIN -> next cycle state START, highScore=0, RGB_out follows RGB_screen_start.
